// File: rtl/matmul_read_ctrl_if.sv
// ============================================================================
// matmul_read_ctrl_if : start/done control plus A/B read and C write buses
// Rev 1.0
// ============================================================================
`default_nettype none

interface matmul_read_ctrl_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 19
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic        [5:0]       a_addr1;
  logic        [5:0]       a_addr2;
  logic signed [DW-1:0]    a_rd1;
  logic signed [DW-1:0]    a_rd2;
  logic        [5:0]       b_addr1;
  logic        [5:0]       b_addr2;
  logic signed [DW-1:0]    b_rd1;
  logic signed [DW-1:0]    b_rd2;
  logic        [5:0]       c_addr;
  logic signed [ACC_W-1:0] c_data;
  logic                    c_wr;

  // master: the sequencer; slave: top-level control plus the three RAMs
  modport master (
    input  start, a_rd1, a_rd2, b_rd1, b_rd2,
    output busy, done, a_addr1, a_addr2, b_addr1, b_addr2, c_addr, c_data, c_wr
  );

  modport slave (
    output start, a_rd1, a_rd2, b_rd1, b_rd2,
    input  busy, done, a_addr1, a_addr2, b_addr1, b_addr2, c_addr, c_data, c_wr
  );
endinterface

`default_nettype wire

// File: rtl/matmul_read_ctrl.sv
// ============================================================================
// matmul_read_ctrl : 8x8 matmul read sequencer, two MACs per cycle into C RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module matmul_read_ctrl #(
  parameter int DW    = 8,
  parameter int ACC_W = 19,
  parameter int N     = 8
) (
  input  wire                 clk,
  input  wire                 rst_n,
  matmul_read_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [2:0] c_LAST_IDX  = 3'(N - 1);
  localparam logic [1:0] c_LAST_PAIR = 2'd3;

  state_t                  r_state;
  logic        [2:0]       r_i;
  logic        [2:0]       r_j;
  logic        [1:0]       r_pair;
  logic                    r_vld;
  logic signed [ACC_W-1:0] r_acc;

  logic                    w_iss;
  logic        [2:0]       w_ni;
  logic        [2:0]       w_nj;
  logic        [1:0]       w_np;
  logic signed [2*DW-1:0]  w_prod1;
  logic signed [2*DW-1:0]  w_prod2;
  logic signed [ACC_W-1:0] w_sum;

  // Coordinates of the next ISSUE cycle, so addresses can be registered ahead of it
  always_comb begin
    w_iss = 1'b0;
    w_ni  = r_i;
    w_nj  = r_j;
    w_np  = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_iss = 1'b1;
          w_ni  = 3'd0;
          w_nj  = 3'd0;
        end
      end
      S_ISSUE: begin
        if (r_pair != c_LAST_PAIR) begin
          w_iss = 1'b1;
          w_np  = r_pair + 2'd1;
        end
      end
      S_WRITE: begin
        if (r_j != c_LAST_IDX) begin
          w_iss = 1'b1;
          w_nj  = r_j + 3'd1;
        end else if (r_i != c_LAST_IDX) begin
          w_iss = 1'b1;
          w_nj  = 3'd0;
          w_ni  = r_i + 3'd1;
        end
      end
      default: begin
        w_iss = 1'b0;
      end
    endcase
  end

  assign w_prod1 = (2*DW)'(bus.a_rd1) * (2*DW)'(bus.b_rd1);
  assign w_prod2 = (2*DW)'(bus.a_rd2) * (2*DW)'(bus.b_rd2);
  assign w_sum   = r_acc + ACC_W'(w_prod1) + ACC_W'(w_prod2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_i         <= 3'd0;
      r_j         <= 3'd0;
      r_pair      <= 2'd0;
      r_vld       <= 1'b0;
      r_acc       <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.c_wr    <= 1'b0;
      bus.c_addr  <= 6'd0;
      bus.c_data  <= '0;
      bus.a_addr1 <= 6'd0;
      bus.a_addr2 <= 6'd0;
      bus.b_addr1 <= 6'd0;
      bus.b_addr2 <= 6'd0;
    end else begin
      bus.c_wr <= 1'b0;
      bus.done <= 1'b0;
      // RAM data lags its address by one cycle
      r_vld    <= (r_state == S_ISSUE);
      if (r_vld) begin
        r_acc <= w_sum;
      end

      // A is indexed by (i, k), B by (k, j); k = 2*pair + port
      bus.a_addr1 <= w_iss ? {w_ni, w_np, 1'b0} : 6'd0;
      bus.a_addr2 <= w_iss ? {w_ni, w_np, 1'b1} : 6'd0;
      bus.b_addr1 <= w_iss ? {w_np, 1'b0, w_nj} : 6'd0;
      bus.b_addr2 <= w_iss ? {w_np, 1'b1, w_nj} : 6'd0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state  <= S_ISSUE;
            r_i      <= 3'd0;
            r_j      <= 3'd0;
            r_pair   <= 2'd0;
            r_acc    <= '0;
            bus.busy <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_pair <= w_np;
          if (!w_iss) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_state    <= S_WRITE;
          bus.c_wr   <= 1'b1;
          bus.c_addr <= {r_i, r_j};
          bus.c_data <= w_sum;
        end
        S_WRITE: begin
          r_acc  <= '0;
          r_pair <= 2'd0;
          r_i    <= w_ni;
          r_j    <= w_nj;
          if (w_iss) begin
            r_state <= S_ISSUE;
          end else begin
            r_state  <= S_FINISH;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_read_ctrl.sv
// ============================================================================
// tb_matmul_read_ctrl : directed self-checking bench with registered RAM models
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_matmul_read_ctrl;

  localparam int DW    = 8;
  localparam int ACC_W = 19;

  logic clk;
  logic rst_n;

  matmul_read_ctrl_if #(.DW(DW), .ACC_W(ACC_W)) bus ();

  matmul_read_ctrl #(.DW(DW), .ACC_W(ACC_W), .N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [DW-1:0] amem [64];
  logic signed [DW-1:0] bmem [64];
  int                   cmem [64];

  // A and B RAMs: registered read, one cycle latency
  always @(posedge clk) begin
    bus.a_rd1 <= amem[bus.a_addr1];
    bus.a_rd2 <= amem[bus.a_addr2];
    bus.b_rd1 <= bmem[bus.b_addr1];
    bus.b_rd2 <= bmem[bus.b_addr2];
  end

  int checks   = 0;
  int failures = 0;

  int wr_n, done_n, done_cyc, first_wr, last_wr, first_addr, last_addr, busy_n;
  int tr_a1, tr_a2, tr_b1, tr_b2;
  bit busy_hist [0:400];

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a run, then observes cycles 1..ncyc (values sampled 1 time unit after each edge)
  task automatic run(input int ncyc, input int pulse_cyc, input int rst_cyc,
                     input bit hold, input int trace_cyc);
    wr_n = 0; done_n = 0; done_cyc = -1; first_wr = -1; last_wr = -1;
    first_addr = -1; last_addr = -1; busy_n = 0;
    for (int n = 0; n < 64; n++) cmem[n] = 12345;
    for (int n = 0; n <= 400; n++) busy_hist[n] = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      bus.start = hold || (k == pulse_cyc);
      if (bus.c_wr) begin
        if (first_wr < 0) begin
          first_wr   = k;
          first_addr = int'(bus.c_addr);
        end
        last_wr   = k;
        last_addr = int'(bus.c_addr);
        wr_n++;
        cmem[bus.c_addr] = int'(bus.c_data);
      end
      if (bus.done) begin
        done_n++;
        done_cyc = k;
      end
      if (bus.busy) busy_n++;
      if (k <= 400) busy_hist[k] = bus.busy;
      if (k == trace_cyc) begin
        tr_a1 = int'(bus.a_addr1);
        tr_a2 = int'(bus.a_addr2);
        tr_b1 = int'(bus.b_addr1);
        tr_b2 = int'(bus.b_addr2);
      end
      if (k == rst_cyc) begin
        check("pre_rst_busy", longint'(bus.busy), 1);
        check("pre_rst_a_addr1", longint'(bus.a_addr1), 22);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_addrs", longint'({bus.a_addr1, bus.a_addr2, bus.b_addr1, bus.b_addr2}), 0);
        check("rst_c_outs", longint'({bus.c_wr, bus.c_addr, bus.c_data}), 0);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_c(input string tag, input int kind);
    int nbad, first_bad, exp_v, got_v;
    nbad = 0; first_bad = -1; exp_v = 0; got_v = 0;
    for (int n = 0; n < 64; n++) begin
      int e;
      e = (kind == 0) ? n : (kind == 1) ? 131072 : 120;
      if (cmem[n] != e) begin
        if (first_bad < 0) begin
          first_bad = n; exp_v = e; got_v = cmem[n];
        end
        nbad++;
      end
    end
    if (nbad != 0) $display("  %s first bad addr=%0d got=%0d want=%0d", tag, first_bad, got_v, exp_v);
    check(tag, nbad, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a_rd1 = '0; bus.a_rd2 = '0; bus.b_rd1 = '0; bus.b_rd2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy_done_wr", longint'({bus.busy, bus.done, bus.c_wr}), 0);
    check("reset_addrs", longint'({bus.a_addr1, bus.a_addr2, bus.b_addr1, bus.b_addr2, bus.c_addr}), 0);
    check("reset_c_data", longint'(bus.c_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity x (8k+j): C[n] = n; stray start at cycle 50 must be ignored
    for (int n = 0; n < 64; n++) begin
      amem[n] = ((n / 8) == (n % 8)) ? 8'sd1 : 8'sd0;
      bmem[n] = 8'(n);
    end
    run(390, 50, 0, 1'b0, 128);
    check_c("ident_C", 0);
    check("ident_first_wr_cyc", first_wr, 6);
    check("ident_first_wr_addr", first_addr, 0);
    check("ident_last_wr_cyc", last_wr, 384);
    check("ident_last_wr_addr", last_addr, 63);
    check("ident_wr_count", wr_n, 64);
    check("ident_done_cyc", done_cyc, 385);
    check("ident_done_count", done_n, 1);
    check("ident_busy_cycles", busy_n, 384);
    check("ident_busy_c1", longint'(busy_hist[1]), 1);
    check("ident_busy_c385", longint'(busy_hist[385]), 0);
    check("trace_a_addr1", tr_a1, 18);
    check("trace_a_addr2", tr_a2, 19);
    check("trace_b_addr1", tr_b1, 21);
    check("trace_b_addr2", tr_b2, 29);

    // Worst-case magnitude: 8 * (-128 * -128)
    for (int n = 0; n < 64; n++) begin
      amem[n] = -8'sd128;
      bmem[n] = -8'sd128;
    end
    run(388, 0, 0, 1'b0, 0);
    check_c("neg128_C", 1);
    check("neg128_wr_count", wr_n, 64);

    // Row 7 of B only reaches the accumulator in DRAIN: 7*(-1) + 127 = 120
    for (int n = 0; n < 64; n++) begin
      amem[n] = 8'sd1;
      bmem[n] = ((n / 8) == 7) ? 8'sd127 : -8'sd1;
    end
    run(388, 0, 0, 1'b0, 0);
    check_c("row7_C", 2);
    check("row7_done_cyc", done_cyc, 385);

    // Reset in cycle 100 aborts; 16 elements were already written, no done
    run(110, 0, 100, 1'b0, 0);
    check("abort_wr_count", wr_n, 16);
    check("abort_done_count", done_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(388, 0, 0, 1'b0, 0);
    check_c("rerun_C", 2);
    check("rerun_wr_count", wr_n, 64);
    check("rerun_done_cyc", done_cyc, 385);

    // Start held high: restart at the first IDLE edge after FINISH
    for (int n = 0; n < 64; n++) begin
      amem[n] = ((n / 8) == (n % 8)) ? 8'sd1 : 8'sd0;
      bmem[n] = 8'(n);
    end
    run(392, 0, 0, 1'b1, 387);
    check("hold_done_cyc", done_cyc, 385);
    check("hold_busy_c386", longint'(busy_hist[386]), 0);
    check("hold_busy_c387", longint'(busy_hist[387]), 1);
    check("hold_a_addr2_c387", tr_a2, 1);
    check("hold_b_addr2_c387", tr_b2, 8);
    check_c("hold_first_run_C", 0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matmul_read_ctrl.md
Name: matmul_read_ctrl

Overview:
- Read-side sequencer for the 8x8 matrix-multiply datapath.
- Drives both read address ports of the A and B dual-read RAMs, consumes their 1-cycle-latency registered outputs, and multiply-accumulates two products per cycle.
- Writes each result element C[i][j] = sum over k of A[i][k]*B[k][j] to the C result RAM.
- Sits between the top-level start/done control and the three RAMs. All matrices are row-major: addr = row*8 + col.

Parameters:
DW, 8, signed element width of A and B
ACC_W, 19, signed accumulator and result width; must be >= 2*DW+3
N, 8, matrix dimension; fixed at 8, so addresses are 6 bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled only in IDLE
busy  out  1  high while a multiply is in progress
done  out  1  one-cycle pulse after the last C write
a_addr1  out  6  A RAM port-1 read address
a_addr2  out  6  A RAM port-2 read address
a_rd1  in  DW  signed A RAM port-1 data, valid 1 cycle after its address
a_rd2  in  DW  signed A RAM port-2 data
b_addr1  out  6  B RAM port-1 read address
b_addr2  out  6  B RAM port-2 read address
b_rd1  in  DW  signed B RAM port-1 data
b_rd2  in  DW  signed B RAM port-2 data
c_addr  out  6  C RAM write address
c_data  out  ACC_W  signed C write data
c_wr  out  1  C RAM write enable

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE; i, j, pair and accumulator are cleared.
  - All outputs are 0: busy, done, c_wr, c_addr, c_data and all address outputs.
- States: IDLE, ISSUE, DRAIN, WRITE, FINISH.
- IDLE:
  - All address outputs are 0.
  - On start=1 at a clock edge: go to ISSUE with i=j=pair=0, accumulator cleared, busy set.
- ISSUE (4 cycles, pair p = 0..3, k0 = 2p, k1 = 2p+1):
  - a_addr1 = 8i+k0, a_addr2 = 8i+k1.
  - b_addr1 = 8*k0+j, b_addr2 = 8*k1+j.
  - Address outputs are registered, so they are valid during the ISSUE cycle itself.
  - After pair 3, go to DRAIN.
- Data arrival: a 1-cycle-delayed valid flag marks the cycle in which RAM data for the previous ISSUE cycle is present (ISSUE cycles 2-4 and DRAIN).
  - In each such cycle: acc <= acc + a_rd1*b_rd1 + a_rd2*b_rd2.
  - Full signed arithmetic: products are 2*DW bits, sign-extended to ACC_W; no saturation.
  - ACC_W=19 covers the worst case 8*(-128*-128) = 131072.
- DRAIN (1 cycle): pair-3 data is accumulated; go to WRITE.
- WRITE (1 cycle):
  - c_wr=1, c_addr=8i+j, c_data=acc (all registered).
  - The accumulator clears at the end of the cycle.
  - If j<7: j++ and go to ISSUE. Else if i<7: j=0, i++ and go to ISSUE. Else go to FINISH.
- FINISH (1 cycle): done=1, busy=0; go to IDLE.
- Timing (cycle 0 = the edge where start is sampled):
  - The element takes 6 cycles: ISSUE in cycles 1-4, DRAIN in 5, WRITE in 6.
  - Element n is written in cycle 6(n+1); last write (addr 63) in cycle 384.
  - done pulses in cycle 385; busy is high in cycles 1-384.
- c_wr is 0 in every state except WRITE.
- start is ignored outside IDLE. A start held high causes a restart at the first IDLE edge after FINISH.
- The RAMs' write enables are not driven by this block. The top level holds them low while busy=1.
- Reset mid-operation aborts with no further C writes and no done pulse. A subsequent start recomputes all 64 elements from scratch.

Test Plan:
- A = identity, B[k][j] = 8k+j (values 0..63), pulse start -> C[n] = n for n = 0..63; first c_wr in cycle 6 with c_addr=0, last in cycle 384 with c_addr=63, done only in cycle 385.
- A and B all -128 -> every c_data = 131072 (no overflow at ACC_W=19).
- A[i][k] = 1, B[k][j] = -1 except B[7][j] = 127 -> every C = 120; checks pair-3 data captured during DRAIN.
- Address trace for element (i=2, j=5), pair 1 -> a_addr1=18, a_addr2=19, b_addr1=21, b_addr2=29.
- Deassert rst_n in cycle 100, release, then start again -> outputs 0 immediately on reset, no done from the first run, second run produces correct full C.
- start held high continuously -> second run's first ISSUE in cycle 387; start pulses during busy have no effect.
